// File: rtl/fwd_hazard_unit.sv
// Forwarding and hazard unit for the filter processor's ID/EX/MEM/WB back end.
// Tracks destination tags in a private shadow pipeline. From that state and
// the instruction in ID it produces ALU forwarding selects for EX, load-use
// or interlock stalls, and a saturating count of stall cycles.
module fwd_hazard_unit #(
  parameter int RADDR_W    = 4,
  parameter int LOAD_STALL = 1,
  parameter int FWD_EN     = 1,
  parameter int ZERO_REG   = 0,
  parameter int CNT_W      = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               id_valid,
  input  logic [RADDR_W-1:0] id_ra,
  input  logic [RADDR_W-1:0] id_rb,
  input  logic               id_re_a,
  input  logic               id_re_b,
  input  logic [RADDR_W-1:0] id_rd,
  input  logic               id_we,
  input  logic               id_load,
  output logic               stall,
  output logic [1:0]         fwd_a,
  output logic [1:0]         fwd_b,
  output logic [CNT_W-1:0]   stall_cnt
);

  // The load-use down-counter reloads LOAD_STALL-1, so two bits cover 1..3.
  localparam logic [1:0]       LU_RELOAD = 2'(LOAD_STALL - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  // A stage produces register r if it is valid and writes r. Register 0 never
  // matches when it is hardwired to zero.
  function automatic logic tag_match(input logic [RADDR_W-1:0] r,
                                     input logic               v,
                                     input logic               we,
                                     input logic [RADDR_W-1:0] rd);
    return v & we & (rd == r) & ~((ZERO_REG != 0) & (r == '0));
  endfunction

  // Shadow pipeline: valids are control and take the reset; tags do not,
  // because every use of a tag is qualified by its stage valid.
  logic               ex_v_q, ex_v_d;
  logic [RADDR_W-1:0] ex_ra_q, ex_rb_q, ex_rd_q;
  logic               ex_re_a_q, ex_re_b_q, ex_we_q, ex_load_q;
  logic               mem_v_q, mem_we_q, mem_load_q;
  logic [RADDR_W-1:0] mem_rd_q;
  logic               wb_v_q, wb_we_q;
  logic [RADDR_W-1:0] wb_rd_q;

  logic [1:0]         lu_cnt_q, lu_cnt_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

  // Source matches for the instruction in ID against EX and MEM producers.
  logic id_a_ex, id_b_ex, id_a_mem, id_b_mem;
  // Source matches for the instruction in EX against MEM and WB producers.
  logic ex_a_mem, ex_b_mem, ex_a_wb, ex_b_wb;
  logic load_hz, raw_hz;

  assign id_a_ex  = id_re_a & tag_match(id_ra, ex_v_q, ex_we_q, ex_rd_q);
  assign id_b_ex  = id_re_b & tag_match(id_rb, ex_v_q, ex_we_q, ex_rd_q);
  assign id_a_mem = id_re_a & tag_match(id_ra, mem_v_q, mem_we_q, mem_rd_q);
  assign id_b_mem = id_re_b & tag_match(id_rb, mem_v_q, mem_we_q, mem_rd_q);

  assign ex_a_mem = ex_v_q & ex_re_a_q & tag_match(ex_ra_q, mem_v_q, mem_we_q, mem_rd_q);
  assign ex_b_mem = ex_v_q & ex_re_b_q & tag_match(ex_rb_q, mem_v_q, mem_we_q, mem_rd_q);
  assign ex_a_wb  = ex_v_q & ex_re_a_q & tag_match(ex_ra_q, wb_v_q, wb_we_q, wb_rd_q);
  assign ex_b_wb  = ex_v_q & ex_re_b_q & tag_match(ex_rb_q, wb_v_q, wb_we_q, wb_rd_q);

  // A load in EX cannot feed ID's consumer until it reaches WB.
  assign load_hz = id_valid & (id_a_ex | id_b_ex) & ex_load_q;
  // Without forwarding, any producer still ahead of WB blocks the consumer;
  // WB itself is safe because the register file writes through.
  assign raw_hz  = id_valid & (id_a_ex | id_b_ex | id_a_mem | id_b_mem);

  // Stall and forwarding selects; MEM wins over WB, and a load in MEM never
  // forwards because the load-use stall already kept its consumer out of EX.
  always_comb begin
    stall = 1'b0;
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (FWD_EN != 0) begin
      stall = ~flush & ((lu_cnt_q != 2'd0) | load_hz);
      if (ex_a_mem & ~mem_load_q) fwd_a = 2'b01;
      else if (ex_a_wb)           fwd_a = 2'b10;
      if (ex_b_mem & ~mem_load_q) fwd_b = 2'b01;
      else if (ex_b_wb)           fwd_b = 2'b10;
    end else begin
      stall = ~flush & raw_hz;
    end
  end

  // Next state: EX takes a bubble on stall or flush; the load-use counter
  // ignores new hazards while it is still draining.
  always_comb begin
    ex_v_d      = id_valid & ~stall & ~flush;
    lu_cnt_d    = 2'd0;
    stall_cnt_d = stall_cnt_q;
    if (flush)                             lu_cnt_d = 2'd0;
    else if (lu_cnt_q != 2'd0)             lu_cnt_d = lu_cnt_q - 2'd1;
    else if ((FWD_EN != 0) && load_hz)     lu_cnt_d = LU_RELOAD;
    if (stall && (stall_cnt_q != CNT_MAX)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  // Control state: stage valids and counters, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_v_q      <= 1'b0;
      mem_v_q     <= 1'b0;
      wb_v_q      <= 1'b0;
      lu_cnt_q    <= 2'd0;
      stall_cnt_q <= '0;
    end else begin
      ex_v_q      <= ex_v_d;
      mem_v_q     <= ex_v_q;
      wb_v_q      <= mem_v_q;
      lu_cnt_q    <= lu_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Tag fields advance every edge; a bubble is marked only by its valid.
  always_ff @(posedge clk) begin
    ex_ra_q    <= id_ra;
    ex_rb_q    <= id_rb;
    ex_re_a_q  <= id_re_a;
    ex_re_b_q  <= id_re_b;
    ex_rd_q    <= id_rd;
    ex_we_q    <= id_we;
    ex_load_q  <= id_load;
    mem_rd_q   <= ex_rd_q;
    mem_we_q   <= ex_we_q;
    mem_load_q <= ex_load_q;
    wb_rd_q    <= mem_rd_q;
    wb_we_q    <= mem_we_q;
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: four configurations side by side, each checked
// every cycle against a model that keeps a history of issued instructions.
`timescale 1ns/1ps
module tb_fwd_hazard_unit;

  localparam int NI = 4;

  // u0 default, u1 LOAD_STALL=3 + ZERO_REG, u2 interlock-only, u3 2-bit counter
  function automatic int cfg_ls(int k);
    case (k)
      1:       return 3;
      3:       return 2;
      default: return 1;
    endcase
  endfunction
  function automatic int cfg_fwd(int k); return (k == 2) ? 0 : 1; endfunction
  function automatic int cfg_zr(int k);  return (k == 1) ? 1 : 0; endfunction
  function automatic int cfg_cw(int k);  return (k == 3) ? 2 : 16; endfunction

  typedef struct packed {
    bit       v;
    bit [3:0] ra;
    bit [3:0] rb;
    bit       rea;
    bit       reb;
    bit [3:0] rd;
    bit       we;
    bit       ld;
  } ins_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       fl [NI];
  logic       iv [NI];
  logic       rea[NI];
  logic       reb[NI];
  logic       iwe[NI];
  logic       ild[NI];
  logic [3:0] ira[NI];
  logic [3:0] irb[NI];
  logic [3:0] ird[NI];

  logic        st[NI];
  logic [1:0]  fa[NI];
  logic [1:0]  fb[NI];
  logic [15:0] sc[NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int CW = cfg_cw(g);
    logic          st_l;
    logic [1:0]    fa_l, fb_l;
    logic [CW-1:0] sc_l;
    fwd_hazard_unit #(
      .RADDR_W(4), .LOAD_STALL(cfg_ls(g)), .FWD_EN(cfg_fwd(g)),
      .ZERO_REG(cfg_zr(g)), .CNT_W(CW)
    ) u_dut (
      .clk(clk), .rst_n(rst_n), .flush(fl[g]), .id_valid(iv[g]),
      .id_ra(ira[g]), .id_rb(irb[g]), .id_re_a(rea[g]), .id_re_b(reb[g]),
      .id_rd(ird[g]), .id_we(iwe[g]), .id_load(ild[g]),
      .stall(st_l), .fwd_a(fa_l), .fwd_b(fb_l), .stall_cnt(sc_l)
    );
    assign st[g] = st_l;
    assign fa[g] = fa_l;
    assign fb[g] = fb_l;
    assign sc[g] = 16'(sc_l);
  end

  // ---------------- reference model ----------------
  // hist[k][n] is the instruction that entered EX n+1 edges ago:
  // n=0 is in EX, n=1 in MEM, n=2 in WB.
  ins_t hist[NI][3];
  int   remain[NI];   // stall cycles still owed by a load-use hazard
  int   scnt[NI];     // stall cycles seen so far, saturating
  bit   es[NI];       // most recent expected stall

  int n_vec = 0;
  int n_err = 0;

  function automatic ins_t cur_ins(int k);
    ins_t c;
    c.v = iv[k]; c.ra = ira[k]; c.rb = irb[k]; c.rea = rea[k]; c.reb = reb[k];
    c.rd = ird[k]; c.we = iwe[k]; c.ld = ild[k];
    return c;
  endfunction

  function automatic bit mt(int k, bit [3:0] r, ins_t s);
    return s.v && s.we && (s.rd == r) && !(cfg_zr(k) != 0 && r == 4'd0);
  endfunction

  function automatic bit m_ldhz(int k);
    ins_t c = cur_ins(k);
    ins_t e = hist[k][0];
    return c.v && ((c.rea && mt(k, c.ra, e)) || (c.reb && mt(k, c.rb, e))) && e.ld;
  endfunction

  function automatic bit m_stall(int k);
    ins_t c  = cur_ins(k);
    ins_t h0 = hist[k][0];
    ins_t h1 = hist[k][1];
    if (fl[k]) return 1'b0;
    if (cfg_fwd(k) != 0) return (remain[k] > 0) || m_ldhz(k);
    return c.v && ((c.rea && (mt(k, c.ra, h0) || mt(k, c.ra, h1))) ||
                   (c.reb && (mt(k, c.rb, h0) || mt(k, c.rb, h1))));
  endfunction

  function automatic int m_fwd(int k, bit sel_b);
    ins_t     e  = hist[k][0];
    bit [3:0] r  = sel_b ? e.rb : e.ra;
    bit       en = sel_b ? e.reb : e.rea;
    if (cfg_fwd(k) == 0 || !e.v || !en) return 0;
    if (mt(k, r, hist[k][1]) && !hist[k][1].ld) return 1;
    if (mt(k, r, hist[k][2])) return 2;
    return 0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      for (int n = 0; n < 3; n++) hist[k][n] = '0;
      remain[k] = 0;
      scnt[k]   = 0;
      es[k]     = 1'b0;
    end
  endtask

  task automatic chk(input string nm, input int k, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s u%0d: got %0d, expected %0d at %0t", nm, k, act, exp, $time);
    end
  endtask

  // Sample away from the rising edge and compare every instance to the model.
  task automatic eval();
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      es[k] = m_stall(k);
      chk("stall", k, 16'(st[k]), 16'(es[k]));
      chk("fwd_a", k, 16'(fa[k]), 16'(m_fwd(k, 1'b0)));
      chk("fwd_b", k, 16'(fb[k]), 16'(m_fwd(k, 1'b1)));
      chk("stall_cnt", k, sc[k], 16'(scnt[k]));
    end
  endtask

  // Advance the model across one rising edge with the inputs currently applied.
  task automatic adv();
    @(posedge clk);
    for (int k = 0; k < NI; k++) begin
      bit s  = m_stall(k);
      bit hz = m_ldhz(k);
      int mx = (1 << cfg_cw(k)) - 1;
      if (s && scnt[k] < mx) scnt[k]++;
      if (fl[k])                           remain[k] = 0;
      else if (remain[k] > 0)              remain[k]--;
      else if (cfg_fwd(k) != 0 && hz)      remain[k] = cfg_ls(k) - 1;
      hist[k][2] = hist[k][1];
      hist[k][1] = hist[k][0];
      hist[k][0] = (s || fl[k]) ? ins_t'('0) : cur_ins(k);
    end
    #1;
  endtask

  task automatic step(); eval(); adv(); endtask

  task automatic set_all(input bit v, input bit [3:0] ra, input bit [3:0] rb, input bit a,
                         input bit b, input bit [3:0] rd, input bit we, input bit ld);
    for (int k = 0; k < NI; k++) begin
      iv[k] = v; ira[k] = ra; irb[k] = rb; rea[k] = a; reb[k] = b;
      ird[k] = rd; iwe[k] = we; ild[k] = ld; fl[k] = 1'b0;
    end
  endtask

  task automatic set_flush(input bit f);
    for (int k = 0; k < NI; k++) fl[k] = f;
  endtask

  // Asynchronous reset with the current inputs still applied: every output
  // must drop before any clock edge.
  task automatic rst_task();
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < NI; k++) begin
      chk("rst_stall", k, 16'(st[k]), 16'd0);
      chk("rst_fwd_a", k, 16'(fa[k]), 16'd0);
      chk("rst_fwd_b", k, 16'(fb[k]), 16'd0);
      chk("rst_cnt",   k, sc[k],      16'd0);
    end
    set_all(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    adv();
  endtask

  task automatic rand_ins(int k);
    iv[k]  = ($urandom % 5) != 0;
    ira[k] = 4'(($urandom % 4 == 0) ? $urandom % 16 : $urandom % 4);
    irb[k] = 4'(($urandom % 4 == 0) ? $urandom % 16 : $urandom % 4);
    ird[k] = 4'(($urandom % 4 == 0) ? $urandom % 16 : $urandom % 4);
    rea[k] = 1'($urandom % 2);
    reb[k] = 1'($urandom % 2);
    iwe[k] = ($urandom % 4) != 0;
    ild[k] = ($urandom % 4) == 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    set_all(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    rst_n = 1'b0;
    #12;
    for (int k = 0; k < NI; k++) begin
      chk("init_stall", k, 16'(st[k]), 16'd0);
      chk("init_fwd_a", k, 16'(fa[k]), 16'd0);
      chk("init_fwd_b", k, 16'(fb[k]), 16'd0);
      chk("init_cnt",   k, sc[k],      16'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    adv();

    // ADD R1,R2,R3 ; SUB R4,R1,R5 : forward from MEM
    set_all(1, 2, 3, 1, 1, 1, 1, 0); step();
    set_all(1, 1, 5, 1, 1, 4, 1, 0); eval();
    chk("t1_nostall", 0, 16'(st[0]), 16'd0);
    adv();
    set_all(0, 0, 0, 0, 0, 0, 0, 0); eval();
    chk("t1_fwd_a", 0, 16'(fa[0]), 16'd1);
    chk("t1_fwd_b", 0, 16'(fb[0]), 16'd0);
    adv();
    step(); step(); step();

    // ADD R1 ; NOP ; ST R1 : forward from WB
    set_all(1, 2, 3, 1, 1, 1, 1, 0); step();
    set_all(0, 0, 0, 0, 0, 0, 0, 0); step();
    set_all(1, 6, 1, 1, 1, 0, 0, 0); step();
    set_all(0, 0, 0, 0, 0, 0, 0, 0); eval();
    chk("t2_wb_fwd_b", 0, 16'(fb[0]), 16'd2);
    chk("t2_wb_fwd_a", 0, 16'(fa[0]), 16'd0);
    adv();
    // ADD R1 ; ADD R1 ; ST R1 : youngest producer (MEM) wins
    set_all(1, 2, 3, 1, 1, 1, 1, 0); step();
    set_all(1, 2, 3, 1, 1, 1, 1, 0); step();
    set_all(1, 6, 1, 1, 1, 0, 0, 0); step();
    set_all(0, 0, 0, 0, 0, 0, 0, 0); eval();
    chk("t2_mem_prio_b", 0, 16'(fb[0]), 16'd1);
    adv();

    // LD R2 ; ADD R3,R2,R2 twice : LOAD_STALL 1/3/2 and counter saturation
    rst_task();
    set_all(1, 7, 0, 1, 0, 2, 1, 1); step();
    set_all(1, 2, 2, 1, 1, 3, 1, 0);
    eval(); chk("ld1_stall", 0, 16'(st[0]), 16'd1); chk("ld3_stall_1", 1, 16'(st[1]), 16'd1); adv();
    eval(); chk("ld1_release", 0, 16'(st[0]), 16'd0); chk("ld3_stall_2", 1, 16'(st[1]), 16'd1); adv();
    eval();
    chk("ld1_fwd_a", 0, 16'(fa[0]), 16'd2);
    chk("ld1_fwd_b", 0, 16'(fb[0]), 16'd2);
    chk("ld1_cnt", 0, sc[0], 16'd1);
    chk("ld3_stall_3", 1, 16'(st[1]), 16'd1);
    adv();
    eval(); chk("ld3_release", 1, 16'(st[1]), 16'd0); chk("ld3_cnt", 1, sc[1], 16'd3);
    chk("ld2_cnt", 3, sc[3], 16'd2);
    adv();
    set_all(1, 7, 0, 1, 0, 2, 1, 1); step();
    set_all(1, 2, 2, 1, 1, 3, 1, 0);
    step(); step(); step(); step();
    set_all(0, 0, 0, 0, 0, 0, 0, 0); eval();
    chk("sat_cnt", 3, sc[3], 16'd3);
    chk("ld3_cnt_twice", 1, sc[1], 16'd6);
    adv();

    // Flush during the second load-use stall cycle
    rst_task();
    set_all(1, 7, 0, 1, 0, 2, 1, 1); step();
    set_all(1, 2, 2, 1, 1, 3, 1, 0);
    eval(); chk("fl_pre_stall", 1, 16'(st[1]), 16'd1); adv();
    set_flush(1); eval(); chk("fl_kills_stall", 1, 16'(st[1]), 16'd0); adv();
    set_flush(0); eval(); chk("fl_no_restall", 1, 16'(st[1]), 16'd0); adv();

    // ADD R0 ; ADD R5,R0,R0 : hardwired zero vs ordinary R0
    rst_task();
    set_all(1, 2, 3, 1, 1, 0, 1, 0); step();
    set_all(1, 0, 0, 1, 1, 5, 1, 0); eval();
    chk("zr_nostall", 1, 16'(st[1]), 16'd0);
    adv();
    set_all(0, 0, 0, 0, 0, 0, 0, 0); eval();
    chk("zr_fwd_a", 1, 16'(fa[1]), 16'd0);
    chk("zr_fwd_b", 1, 16'(fb[1]), 16'd0);
    chk("r0_fwd_a", 0, 16'(fa[0]), 16'd1);
    chk("r0_fwd_b", 0, 16'(fb[0]), 16'd1);
    adv();

    // Interlock-only: ADD R1 ; SUB R4,R1,R5 stalls while producer is in EX and MEM
    rst_task();
    set_all(1, 2, 3, 1, 1, 1, 1, 0); step();
    set_all(1, 1, 5, 1, 1, 4, 1, 0);
    eval(); chk("il_stall_ex", 2, 16'(st[2]), 16'd1); chk("il_fwd_a", 2, 16'(fa[2]), 16'd0); adv();
    eval(); chk("il_stall_mem", 2, 16'(st[2]), 16'd1); chk("il_fwd_b", 2, 16'(fb[2]), 16'd0); adv();
    eval(); chk("il_release", 2, 16'(st[2]), 16'd0); chk("il_cnt", 2, sc[2], 16'd2); adv();
    // Reset in the middle of an interlock stall
    set_all(1, 2, 3, 1, 1, 1, 1, 0); step();
    set_all(1, 1, 5, 1, 1, 4, 1, 0);
    eval(); chk("il_mid_stall", 2, 16'(st[2]), 16'd1);
    rst_task();

    // Randomized traffic; a stalled instance keeps its ID instruction
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < NI; k++) begin
        if (!es[k]) rand_ins(k);
        fl[k] = ($urandom % 20) == 0;
      end
      if (($urandom % 600) == 0) rst_task();
      else step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
